// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM states, bus constants and range helper for the I2C slave register bank
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    REG,
    ACK_REG,
    WR,
    ACK_WR,
    RD,
    MACK
  } i2c_state_t;

  localparam logic I2C_ACK    = 1'b0;
  localparam int   SYNC_DEPTH = 3;

  function automatic logic reg_in_range(input logic [7:0] addr, input int reg_num);
    return int'({24'd0, addr}) < reg_num;
  endfunction

endpackage

// File: rtl/i2c_bus_cond.sv
// rtl/i2c_bus_cond.sv - SCL/SDA synchronizers with edge, START and STOP detection
module i2c_bus_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_DEPTH-1:0] r_scl_sh;
  logic [SYNC_DEPTH-1:0] r_sda_sh;
  logic                  w_scl_cur;
  logic                  w_scl_prev;
  logic                  w_sda_cur;
  logic                  w_sda_prev;

  // Reset to the idle-high bus level so release from reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sh <= '1;
      r_sda_sh <= '1;
    end else begin
      r_scl_sh <= {r_scl_sh[SYNC_DEPTH-2:0], scl_i};
      r_sda_sh <= {r_sda_sh[SYNC_DEPTH-2:0], sda_i};
    end
  end

  assign w_scl_cur  = r_scl_sh[SYNC_DEPTH-2];
  assign w_scl_prev = r_scl_sh[SYNC_DEPTH-1];
  assign w_sda_cur  = r_sda_sh[SYNC_DEPTH-2];
  assign w_sda_prev = r_sda_sh[SYNC_DEPTH-1];

  assign scl_rise  = w_scl_cur & ~w_scl_prev;
  assign scl_fall  = ~w_scl_cur & w_scl_prev;
  assign start_det = w_scl_cur & w_scl_prev & w_sda_prev & ~w_sda_cur;
  assign stop_det  = w_scl_cur & w_scl_prev & ~w_sda_prev & w_sda_cur;
  assign sda_s     = w_sda_cur;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C slave register bank; I2C_SLV_AUTOINC_EN enables pointer auto-increment
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         REG_NUM  = 16,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_vld,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_raddr,
  output logic [7:0] host_rdata,
  output logic       busy
);

  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda_s;
  logic [7:0] w_byte_in;
  logic [7:0] w_rd_cur;

  i2c_state_t r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic [7:0] r_rd_byte;
  logic       r_mack;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_wr_vld;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_regs [REG_NUM];

  i2c_bus_cond u_bus_cond (
    .clk       (clk_50M),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );

  assign w_byte_in  = {r_shift[6:0], w_sda_s};
  assign w_rd_cur   = reg_in_range(r_ptr, REG_NUM) ? r_regs[r_ptr[AW-1:0]] : 8'h00;
  assign host_rdata = reg_in_range(host_raddr, REG_NUM) ? r_regs[host_raddr[AW-1:0]] : 8'h00;

`ifdef I2C_SLV_AUTOINC_EN
  logic [7:0] w_ptr_nxt;
  logic [7:0] w_rd_nxt;
  assign w_ptr_nxt = r_ptr + 8'd1;
  assign w_rd_nxt  = reg_in_range(w_ptr_nxt, REG_NUM) ? r_regs[w_ptr_nxt[AW-1:0]] : 8'h00;
`endif

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_rd_byte <= '0;
      r_mack    <= 1'b1;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_vld  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= RST_VAL;
    end else begin
      r_wr_vld <= 1'b0;
      // Bus conditions win over any bit activity seen in the same clock.
      if (w_start) begin
        r_state   <= DEV;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;
          DEV: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= '0;
              if (r_shift[7:1] == DEV_ADDR) begin
                r_state  <= ACK_DEV;
                r_sda_oe <= ~I2C_ACK;
                r_busy   <= 1'b1;
                r_rw     <= r_shift[0];
              end else begin
                r_state <= IDLE;
              end
            end
          end
          ACK_DEV: begin
            if (w_scl_fall) begin
              r_bit_cnt <= '0;
              if (r_rw) begin
                r_state   <= RD;
                r_rd_byte <= w_rd_cur;
                r_sda_oe  <= ~w_rd_cur[7];
              end else begin
                r_state  <= REG;
                r_sda_oe <= 1'b0;
              end
            end
          end
          REG: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_ptr     <= r_shift;
              r_state   <= ACK_REG;
              r_sda_oe  <= ~I2C_ACK;
              r_bit_cnt <= '0;
            end
          end
          ACK_REG: begin
            if (w_scl_fall) begin
              r_state   <= WR;
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
            end
          end
          WR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte_in;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_wr_vld  <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte_in;
                if (reg_in_range(r_ptr, REG_NUM)) r_regs[r_ptr[AW-1:0]] <= w_byte_in;
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_state   <= ACK_WR;
              r_sda_oe  <= ~I2C_ACK;
              r_bit_cnt <= '0;
            end
          end
          ACK_WR: begin
            if (w_scl_fall) begin
              r_state   <= WR;
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= '0;
`ifdef I2C_SLV_AUTOINC_EN
              r_ptr     <= w_ptr_nxt;
`endif
            end
          end
          RD: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_state  <= MACK;
                r_sda_oe <= 1'b0;
              end else begin
                r_rd_byte <= {r_rd_byte[6:0], 1'b0};
                r_sda_oe  <= ~r_rd_byte[6];
              end
            end
          end
          MACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda_s;
            end else if (w_scl_fall) begin
              r_bit_cnt <= '0;
              if (r_mack == I2C_ACK) begin
                r_state <= RD;
`ifdef I2C_SLV_AUTOINC_EN
                r_ptr     <= w_ptr_nxt;
                r_rd_byte <= w_rd_nxt;
                r_sda_oe  <= ~w_rd_nxt[7];
`else
                r_rd_byte <= w_rd_cur;
                r_sda_oe  <= ~w_rd_cur[7];
`endif
              end else begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe  = r_sda_oe;
  assign busy    = r_busy;
  assign wr_vld  = r_wr_vld;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
